// File: rtl/mmio_uart_tx_pkg.sv
// uart_pkg: shared types/constants for mmio_uart_tx.
// UART_TX_PARITY_EN adds the PARITY state to the FSM enum.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STS_FULL_BIT  = 0;
  localparam int STS_EMPTY_BIT = 1;
  localparam int STS_BUSY_BIT  = 2;
  localparam int STS_OVF_BIT   = 3;
  localparam int STS_CNT_LSB   = 8;

  function automatic logic [31:0] status_word(
    input logic [7:0] cnt,
    input logic       ovf,
    input logic       busy,
    input logic       empty,
    input logic       full
  );
    logic [31:0] w;
    w = 32'h0;
    w[STS_CNT_LSB +: 8] = cnt;
    w[STS_OVF_BIT]      = ovf;
    w[STS_BUSY_BIT]     = busy;
    w[STS_EMPTY_BIT]    = empty;
    w[STS_FULL_BIT]     = full;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor MMIO bus bundle for mmio_uart_tx.
// Master drives address/data/strobe, slave returns readback.
interface mmio_uart_tx_if;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (
    output adr, wdata, we,
    input  rdata
  );

  modport slave (
    input  adr, wdata, we,
    output rdata
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth.
// Push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // pointer/count next state; pointers wrap naturally
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO transmit-only UART with FIFO.
// Define UART_TX_PARITY_EN to add an even parity bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h0000_2000,
  parameter int          BAUD_DIV   = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic [31:0] data_adr_pi,
  input  logic [31:0] write_data_pi,
  input  logic        mem_write_pi,
  output logic [31:0] read_data_po,
  output logic        tx_po
);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          sel_tx, sel_sts;
  logic          wr_tx, wr_sts;
  logic          push, pop;
  logic [7:0]    fifo_dout;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          baud_end;
  logic          unused_wdata;

  assign sel_tx  = (data_adr_pi == BASE_ADR + TXDATA_OFS);
  assign sel_sts = (data_adr_pi == BASE_ADR + STATUS_OFS);
  assign wr_tx   = mem_write_pi & sel_tx;
  assign wr_sts  = mem_write_pi & sel_sts;
  assign push    = wr_tx & ~full;
  assign busy    = (state_q != ST_IDLE);
  assign tx_po   = tx_q;

  assign unused_wdata = ^write_data_pi[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_pi),
    .rst_n (reset_pi),
    .push  (push),
    .din   (write_data_pi[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // status readback, zero elsewhere
  always_comb begin
    read_data_po = 32'h0;
    if (sel_sts) begin
      read_data_po = status_word(
        8'(count), ovf_q, busy, empty, full);
    end
  end

  // sticky overflow: set on dropped push, cleared by STATUS store
  always_comb begin
    ovf_d = ovf_q;
    if (wr_sts)       ovf_d = 1'b0;
    if (wr_tx & full) ovf_d = 1'b1;
  end

  // transmit FSM next state and serial output
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          state_d = ST_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = sh_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^sh_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FSM, counters, line and flag registers
  always_ff @(posedge clk_pi or negedge reset_pi) begin
    if (!reset_pi) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (BAUD_DIV=4, depth 4).
// Honours UART_TX_PARITY_EN for frame shape and length.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int BD    = 4;
  localparam int FRAME = NBITS * BD;
  localparam logic [31:0] TXA = 32'h2000;
  localparam logic [31:0] STA = 32'h2004;

  logic clk;
  logic rst_n;
  logic tx;
  int   total;
  int   passed;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADR   (32'h2000),
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_pi        (clk),
    .reset_pi      (rst_n),
    .data_adr_pi   (bus.adr),
    .write_data_pi (bus.wdata),
    .mem_write_pi  (bus.we),
    .read_data_po  (bus.rdata),
    .tx_po         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic store(
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    bus.adr   = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic rd(
    input  logic [31:0] a,
    output logic [31:0] v
  );
    bus.adr = a;
    #1;
    v = bus.rdata;
  endtask

  function automatic logic exp_bit(
    input logic [7:0] d,
    input int         bt
  );
    if (bt == 0) return 1'b0;
    if (bt <= 8) return d[bt-1];
`ifdef UART_TX_PARITY_EN
    if (bt == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // starts on the negedge of the first start-bit sample
  task automatic check_frame(input logic [7:0] d);
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("frame%02h_c%0d", d, i),
            {31'b0, tx}, {31'b0, exp_bit(d, i / BD)});
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          lows;
    bit          done;
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    bus.adr   = STA;
    bus.wdata = 32'h0;
    bus.we    = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'h1);
    rd(STA, v);
    check("rst_status", v, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_tx", {31'b0, tx}, 32'h1);

    // single frame 0x55, upper bits ignored
    store(TXA, 32'hFFFF_FF55);
    @(negedge clk);
    check_frame(8'h55);
    rd(STA, v);
    check("f55_done_status", v, 32'h2);

    // unmapped accesses
    rd(32'h2008, v);
    check("rd_2008", v, 32'h0);
    rd(TXA, v);
    check("rd_txdata", v, 32'h0);
    store(32'h1FFC, 32'h0000_0041);
    rd(STA, v);
    check("st_1ffc_status", v, 32'h2);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    check("st_1ffc_line", 32'(lows), 32'h0);

    // parity/length frame 0x07
    store(TXA, 32'h0000_0007);
    @(negedge clk);
    check_frame(8'h07);
    rd(STA, v);
    check("f07_done_status", v, 32'h2);

    // six back-to-back stores: one pops, four queue, one drops
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.adr   = TXA;
      bus.wdata = 32'h10 + 32'(i);
      bus.we    = 1'b1;
      @(negedge clk);
    end
    bus.we = 1'b0;
    rd(STA, v);
    check("ovf_status", v, 32'h0000_040D);
    store(STA, 32'hFFFF_FFFF);
    rd(STA, v);
    check("ovf_cleared", v, 32'h0000_0405);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      rd(STA, v);
      if (v == 32'h2) done = 1'b1;
    end
    check("drain_done", {31'b0, done}, 32'h1);

    // two queued bytes, no gap between frames
    @(negedge clk);
    bus.adr   = TXA;
    bus.wdata = 32'hA5;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.wdata = 32'h3C;
    @(negedge clk);
    bus.we    = 1'b0;
    check_frame(8'hA5);
    check_frame(8'h3C);
    rd(STA, v);
    check("b2b_done_status", v, 32'h2);

    // reset during DATA bit 3 with a byte still queued
    store(TXA, 32'h55);
    store(TXA, 32'h0F);
    repeat (16) @(negedge clk);
    check("pre_rst_bit3", {31'b0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'b0, tx}, 32'h1);
    rd(STA, v);
    check("abort_status_in_rst", v, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rd(STA, v);
    check("abort_status", v, 32'h2);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    check("abort_no_frame", 32'(lows), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
